// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store engine between the core memory stage and a word-organized data
// memory port. One request is accepted per valid/ready handshake. Aligned
// accesses go straight through in one memory cycle; misaligned halfword/word
// accesses are split into two aligned word reads (loads are assembled from
// them) followed, for stores, by two word writes (read-modify-write).
//
// State table
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   ACC   | single aligned memory access, memory does lane select/extension
//   RD0   | read low aligned word of a misaligned access
//   RD1   | read next aligned word (base+4, wraps at 2^32)
//   WR0   | write merged low word (misaligned store)
//   WR1   | write merged high word (misaligned store)
//   RESP  | response held until resp_ready
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_req_*, o_req_ready   request channel (we, byte addr, right-aligned
//                          wdata, funct3-style mask)
//   o_resp_*, i_resp_ready response channel (rdata, err)
//   o_mem_*, i_mem_rdata   memory port, combinational read data
module lsu_mem_master (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [2:0]  i_req_mask,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [2:0]  o_mem_mask,
   output logic        o_mem_wr_en,
   output logic        o_mem_rd_en,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC  = 3'd1,
      RD0  = 3'd2,
      RD1  = 3'd3,
      WR0  = 3'd4,
      WR1  = 3'd5,
      RESP = 3'd6
   } state_t;

   state_t r_state;
   state_t w_next;

   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_mask;
   logic [31:0] r_lo;
   logic [31:0] r_hi;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_req_illegal;
   logic        w_req_misaligned;
   logic [1:0]  w_off;
   logic [31:0] w_base;
   logic [31:0] w_base_nx;
   logic [5:0]  w_shift;
   logic [63:0] w_nmask;
   logic [63:0] w_load_buf;
   logic [63:0] w_load_field;
   logic [31:0] w_load_result;
   logic [63:0] w_store_buf;
   logic [63:0] w_lane;
   logic [63:0] w_merged;

   // Legal masks: 000/001/010 for both directions, 100/101 for loads only.
   function automatic logic is_illegal(input logic we, input logic [2:0] mask);
      logic bad;
      bad = 1'b0;
      case (mask)
         3'b000, 3'b001, 3'b010: bad = 1'b0;
         3'b100, 3'b101:         bad = we;
         default:                bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Halfword at offset 1 still fits in one word, so only offset 3 splits.
   function automatic logic is_misaligned(input logic [2:0] mask, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (mask[1:0])
         2'b01:   mis = (off == 2'd3);
         2'b10:   mis = (off != 2'd0);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   assign o_req_ready      = (r_state == IDLE) && !i_reset;
   assign w_accept         = i_req_valid && o_req_ready;
   assign w_req_illegal    = is_illegal(i_req_we, i_req_mask);
   assign w_req_misaligned = is_misaligned(i_req_mask, i_req_addr[1:0]);

   assign w_off     = r_addr[1:0];
   assign w_base    = {r_addr[31:2], 2'b00};
   assign w_base_nx = w_base + 32'd4;
   assign w_shift   = {1'b0, w_off, 3'b000};

   always_comb begin
      w_nmask = 64'h0000_0000_0000_00FF;
      case (r_mask[1:0])
         2'b01:   w_nmask = 64'h0000_0000_0000_FFFF;
         2'b10:   w_nmask = 64'h0000_0000_FFFF_FFFF;
         default: w_nmask = 64'h0000_0000_0000_00FF;
      endcase
   end

   // Misaligned load: hi word arrives combinationally in RD1.
   assign w_load_buf   = {i_mem_rdata, r_lo};
   assign w_load_field = w_load_buf >> w_shift;

   always_comb begin
      w_load_result = w_load_field[31:0];
      case (r_mask)
         3'b001:  w_load_result = {{16{w_load_field[15]}}, w_load_field[15:0]};
         3'b101:  w_load_result = {16'h0000, w_load_field[15:0]};
         default: w_load_result = w_load_field[31:0];
      endcase
   end

   // Misaligned store: merge right-aligned store data into the two words read.
   assign w_store_buf = {r_hi, r_lo};
   assign w_lane      = w_nmask << w_shift;
   assign w_merged    = (w_store_buf & ~w_lane) |
                        (({32'h0000_0000, r_wdata} & w_nmask) << w_shift);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_req_illegal)         w_next = RESP;
               else if (w_req_misaligned) w_next = RD0;
               else                       w_next = ACC;
            end
         end
         ACC:  w_next = RESP;
         RD0:  w_next = RD1;
         RD1:  w_next = r_we ? WR0 : RESP;
         WR0:  w_next = WR1;
         WR1:  w_next = RESP;
         RESP: if (i_resp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_mem_addr  = 32'h0;
      o_mem_wdata = 32'h0;
      o_mem_mask  = 3'b000;
      o_mem_wr_en = 1'b0;
      o_mem_rd_en = 1'b0;
      case (r_state)
         ACC: begin
            o_mem_addr  = r_addr;
            o_mem_mask  = r_mask;
            o_mem_wdata = r_we ? r_wdata : 32'h0;
            o_mem_wr_en = r_we;
            o_mem_rd_en = !r_we;
         end
         RD0: begin
            o_mem_addr  = w_base;
            o_mem_mask  = 3'b010;
            o_mem_rd_en = 1'b1;
         end
         RD1: begin
            o_mem_addr  = w_base_nx;
            o_mem_mask  = 3'b010;
            o_mem_rd_en = 1'b1;
         end
         WR0: begin
            o_mem_addr  = w_base;
            o_mem_mask  = 3'b010;
            o_mem_wdata = w_merged[31:0];
            o_mem_wr_en = 1'b1;
         end
         WR1: begin
            o_mem_addr  = w_base_nx;
            o_mem_mask  = 3'b010;
            o_mem_wdata = w_merged[63:32];
            o_mem_wr_en = 1'b1;
         end
         default: begin
            o_mem_addr = 32'h0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_we         <= 1'b0;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_mask       <= 3'b000;
         r_lo         <= 32'h0;
         r_hi         <= 32'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_resp_valid <= (w_next == RESP);
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_we         <= i_req_we;
                  r_addr       <= i_req_addr;
                  r_wdata      <= i_req_wdata;
                  r_mask       <= i_req_mask;
                  r_resp_rdata <= 32'h0;
                  r_resp_err   <= w_req_illegal;
               end
            end
            ACC: begin
               if (!r_we) r_resp_rdata <= i_mem_rdata;
            end
            RD0: r_lo <= i_mem_rdata;
            RD1: begin
               r_hi <= i_mem_rdata;
               if (!r_we) r_resp_rdata <= w_load_result;
            end
            RESP: begin
               if (i_resp_ready) begin
                  r_resp_rdata <= 32'h0;
                  r_resp_err   <= 1'b0;
               end
            end
            default: begin
               r_lo <= r_lo;
            end
         endcase
      end
   end

   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_mask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_mask;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;

   lsu_mem_master dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_mask   (req_mask),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_mem_mask   (mem_mask),
      .o_mem_wr_en  (mem_wr_en),
      .o_mem_rd_en  (mem_rd_en),
      .i_mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory model with funct3 lane handling for single-cycle accesses.
   logic [31:0] mem [logic [29:0]];
   int          mem_gen = 0;
   logic [31:0] log_addr[$];
   logic        log_wr[$];

   function automatic logic [31:0] rd_word(input logic [29:0] idx);
      if (mem.exists(idx)) return mem[idx];
      return 32'h0;
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] m);
      logic [31:0] w, s, r;
      w = rd_word(a[31:2]);
      s = w >> {a[1:0], 3'b000};
      case (m)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b100:  r = {24'h0, s[7:0]};
         3'b101:  r = {16'h0, s[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   always @(mem_addr or mem_mask or mem_rd_en or mem_gen) begin
      mem_rdata = mem_rd_en ? mem_read(mem_addr, mem_mask) : 32'h0;
   end

   always @(negedge clk) begin
      logic [31:0] w, lanes, sh;
      if (mem_rd_en || mem_wr_en) begin
         log_addr.push_back(mem_addr);
         log_wr.push_back(mem_wr_en);
      end
      if (mem_wr_en) begin
         w  = rd_word(mem_addr[31:2]);
         sh = {27'h0, mem_addr[1:0], 3'b000};
         case (mem_mask[1:0])
            2'b00:   lanes = 32'h0000_00FF << sh;
            2'b01:   lanes = 32'h0000_FFFF << sh;
            default: lanes = 32'hFFFF_FFFF;
         endcase
         mem[mem_addr[31:2]] = (w & ~lanes) | ((mem_wdata << sh) & lanes);
         mem_gen = mem_gen + 1;
      end
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mask;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      logic [31:0] exp_a;
      logic        exp_w;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", idx), {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_mask  = v.mask;
      resp_ready = 1'b0;
      log_addr.delete();
      log_wr.delete();
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
      chk($sformatf("v%0d err", idx), {31'h0, resp_err}, {31'h0, v.exp_err});
      chk($sformatf("v%0d strobes", idx), log_addr.size(), (v.exp_lat > 1) ? v.exp_lat - 1 : 0);
      for (int k = 0; k < log_addr.size(); k++) begin
         if (v.exp_lat == 2) begin
            exp_a = v.addr;
            exp_w = v.we;
         end else begin
            exp_a = {v.addr[31:2], 2'b00} + ((k % 2 == 1) ? 32'd4 : 32'd0);
            exp_w = v.we && (k >= 2);
         end
         chk($sformatf("v%0d strobe%0d addr", idx, k), log_addr[k], exp_a);
         chk($sformatf("v%0d strobe%0d wr", idx, k), {31'h0, log_wr[k]}, {31'h0, exp_w});
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk($sformatf("v%0d resp_valid after handshake", idx), {31'h0, resp_valid}, 32'h0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h0);
      chk({tag, " resp_rdata"}, resp_rdata, 32'h0);
      chk({tag, " resp_err"}, {31'h0, resp_err}, 32'h0);
      chk({tag, " mem_addr"}, mem_addr, 32'h0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, " mem_ctl"}, {27'h0, mem_mask, mem_wr_en, mem_rd_en}, 32'h0);
   endtask

   initial begin
      int cnt;
      int wr_seen;
      logic [31:0] held;

      vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b010, 32'h4433_2211, 1'b0, 2};
      vecs[1]  = '{1'b0, 32'h0000_0102, 32'h0,         3'b010, 32'h6655_4433, 1'b0, 3};
      vecs[2]  = '{1'b0, 32'h0000_0103, 32'h0,         3'b001, 32'h0000_5544, 1'b0, 3};
      vecs[3]  = '{1'b0, 32'h0000_0107, 32'h0,         3'b000, 32'hFFFF_FF88, 1'b0, 2};
      vecs[4]  = '{1'b0, 32'h0000_0101, 32'h0,         3'b101, 32'h0000_3322, 1'b0, 2};
      vecs[5]  = '{1'b0, 32'h0000_0105, 32'h0,         3'b100, 32'h0000_0066, 1'b0, 2};
      vecs[6]  = '{1'b1, 32'h0000_0103, 32'h1234_ABCD, 3'b001, 32'h0,         1'b0, 5};
      vecs[7]  = '{1'b0, 32'h0000_0104, 32'h0,         3'b010, 32'h8877_66AB, 1'b0, 2};
      vecs[8]  = '{1'b1, 32'h0000_0102, 32'hFFFF_FF77, 3'b000, 32'h0,         1'b0, 2};
      vecs[9]  = '{1'b0, 32'h0000_0100, 32'h0,         3'b010, 32'hCD77_2211, 1'b0, 2};
      vecs[10] = '{1'b0, 32'hFFFF_FFFE, 32'h0,         3'b010, 32'h0201_DDCC, 1'b0, 3};
      vecs[11] = '{1'b0, 32'h0000_0100, 32'h0,         3'b011, 32'h0,         1'b1, 1};
      vecs[12] = '{1'b1, 32'h0000_0100, 32'h5555_5555, 3'b101, 32'h0,         1'b1, 1};
      vecs[13] = '{1'b1, 32'h0000_0100, 32'h5555_5555, 3'b111, 32'h0,         1'b1, 1};
      vecs[14] = '{1'b0, 32'h0000_01FF, 32'h0,         3'b001, 32'hFFFF_CDAB, 1'b0, 3};
      vecs[15] = '{1'b0, 32'h0000_01FF, 32'h0,         3'b101, 32'h0000_CDAB, 1'b0, 3};
      vecs[16] = '{1'b1, 32'h0000_01FE, 32'h1122_3344, 3'b010, 32'h0,         1'b0, 5};
      vecs[17] = '{1'b0, 32'h0000_01FC, 32'h0,         3'b010, 32'h3344_0000, 1'b0, 2};
      vecs[18] = '{1'b0, 32'h0000_0200, 32'h0,         3'b010, 32'h0000_1122, 1'b0, 2};

      mem[30'h40]        = 32'h4433_2211;
      mem[30'h41]        = 32'h8877_6655;
      mem[30'h3FFF_FFFF] = 32'hDDCC_BBAA;
      mem[30'h0]         = 32'h0403_0201;
      mem[30'h7F]        = 32'hAB00_0000;
      mem[30'h80]        = 32'h0000_00CD;
      mem_gen = 1;

      reset = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      req_mask = 3'b000;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset req_ready", {31'h0, req_ready}, 32'h0);
      chk_idle_outputs("reset");
      reset = 1'b0;
      #1;
      chk("post-reset req_ready", {31'h0, req_ready}, 32'h1);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Response stall: everything held, no new request accepted.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0100;
      req_mask  = 3'b010;
      @(negedge clk);
      cnt = 0;
      while (!resp_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("stall reached resp", {31'h0, resp_valid}, 32'h1);
      held = resp_rdata;
      chk("stall rdata", held, 32'hCD77_2211);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("stall resp_valid", {31'h0, resp_valid}, 32'h1);
         chk("stall rdata held", resp_rdata, 32'hCD77_2211);
         chk("stall req_ready", {31'h0, req_ready}, 32'h0);
         chk("stall mem quiet", {mem_addr[28:0], mem_wr_en, mem_rd_en, 1'b0}, 32'h0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("stall release req_ready", {31'h0, req_ready}, 32'h1);
      chk("stall release resp_valid", {31'h0, resp_valid}, 32'h0);

      // Reset during WR0 of a misaligned word store.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0000_0101;
      req_wdata = 32'hAABB_CCDD;
      req_mask  = 3'b010;
      log_addr.delete();
      log_wr.delete();
      @(negedge clk);
      req_valid = 1'b0;
      cnt = 0;
      while (!mem_wr_en && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst WR0 reached", {31'h0, mem_wr_en}, 32'h1);
      chk("rst WR0 addr", mem_addr, 32'h0000_0100);
      chk("rst WR0 data", mem_wdata, 32'hBBCC_DD11);
      reset = 1'b1;
      @(negedge clk);
      chk("rst no WR1", {31'h0, mem_wr_en}, 32'h0);
      chk("rst req_ready low", {31'h0, req_ready}, 32'h0);
      chk_idle_outputs("rst");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst release req_ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      chk_idle_outputs("rst release");
      wr_seen = 0;
      foreach (log_wr[k]) if (log_wr[k]) wr_seen++;
      chk("rst write count", wr_seen, 1);
      chk("rst mem lo", rd_word(30'h40), 32'hBBCC_DD11);
      chk("rst mem hi", rd_word(30'h41), 32'h8877_66AB);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Initiator-side load/store engine between the core's memory stage and the word-organized data memory port (addr/wdata/mask/wr_en/rd_en/rdata, combinational read, write on falling clock edge). Accepts one load or store per valid/ready handshake and drives the memory with RISC-V funct3-style masks. Aligned accesses pass through in a single memory cycle. Misaligned halfword/word accesses are split into two aligned word accesses: loads are assembled, and stores are performed as read-modify-write. Results return on a valid/ready response channel.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE; request accepted on rising edge with req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_mask  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; others illegal.
- resp_valid  out  1  response valid; held until resp_ready.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors.
- resp_err  out  1  illegal mask (including 100/101 with req_we=1).
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_mask  out  3  memory access mask.
- mem_wr_en  out  1  memory write strobe.
- mem_rd_en  out  1  memory read strobe.
- mem_rdata  in  32  memory read data, valid in the same cycle as mem_rd_en.

## Operation
- On accept, register we, addr, wdata, mask. Compute off = addr[1:0], size n = 1/2/4 bytes.
- Misaligned means (n=2 and off=3) or (n=4 and off!=0). Halfword at off=1 fits inside one word, so it is aligned for this block.
- States:
  - IDLE: wait for a request. Illegal request -> RESP. Aligned request -> ACC. Misaligned request -> RD0.
  - ACC: drive mem_addr=addr, mem_mask=mask, mem_wdata=wdata, and strobe mem_rd_en or mem_wr_en. For loads, capture mem_rdata directly as the result, since memory performs the extension. Next state RESP.
  - RD0: mem_addr = {addr[31:2],2'b00}, mem_mask=010, mem_rd_en=1. Capture lo word. Next state RD1.
  - RD1: mem_addr = base+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). Capture hi word. Loads -> RESP; stores -> WR0.
  - WR0: mem_wr_en=1, mask 010, base address, data = merged[31:0]. Next state WR1.
  - WR1: mem_wr_en=1, mask 010, base+4, data = merged[63:32]. Next state RESP.
  - RESP: resp_valid=1. Go to IDLE on the edge where resp_ready=1.
- Misaligned load: buf = {hi,lo}, field = buf >> (8*off), truncated to n bytes. Sign-extend for 001; zero-extend for 101.
- Misaligned store: lane mask m = ((1<<8n)-1) << (8*off), 64-bit. merged = (buf & ~m) | ((wdata & ((1<<8n)-1)) << 8*off).
- In IDLE and RESP, all mem_* outputs are 0. No memory strobe is asserted outside ACC/RD0/RD1/WR0/WR1.

## Timing
- Reset: state IDLE. resp_valid=0, resp_rdata=0, resp_err=0, all mem_* = 0. req_ready=1 in the first cycle after reset deasserts (it is combinational from state==IDLE and low while reset=1).
- Reset mid-operation: abort immediately on the reset edge with no further strobes. A store aborted after WR0 leaves the lo word already written; this non-atomic behaviour is accepted.
- Latency from accept edge to the first resp_valid cycle:
  - aligned: 2 cycles (ACC, RESP).
  - misaligned load: 3 cycles.
  - misaligned store: 5 cycles.
  - illegal: 1 cycle.
- resp_valid, resp_rdata and resp_err are registered and stable while stalled in RESP.
- There is no back-to-back acceptance: the next request is accepted no earlier than the cycle after response handshake.
- Memory writes complete on the falling edge inside WR0/WR1/ACC. RD1 and WR0 for the same word therefore observe consistent data.

## Test plan
- Preload mem[0x100]=0x44332211. Issue lw 0x100 -> 1 ACC cycle with mask 010; resp_rdata=0x44332211 two cycles after accept.
- Preload mem[0x104]=0x88776655. Issue lw 0x102 -> reads at 0x100 then 0x104; resp_rdata=0x66554433. Issue lh 0x103 -> 0x00005544. Issue lb 0x107 -> 0xFFFFFF88.
- Issue sh 0x103 with wdata 0x1234ABCD -> RD0, RD1, WR0, WR1 sequence; mem[0x100]=0xCD332211, mem[0x104]=0x887766AB; resp_rdata=0.
- Issue lw 0xFFFFFFFE -> second read at mem_addr 0x00000000. Issue req_mask=011 -> no mem strobes; resp_err=1 one cycle after accept.
- Hold resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stable, req_ready=0; resp_ready=1 -> IDLE next cycle.
- Assert reset during WR0 of sw 0x101 -> no WR1 strobe; outputs 0 and req_ready=1 after reset release.
